instr_encode_loader: RTL and testbench

//  Inverse of the main opcode decoder: turns field-level instruction requests into
//  32-bit MIPS words and writes them one by one into instruction memory.

---
 rtl/instr_encode_loader_if.sv | 38 +++
 rtl/instr_encode_loader.sv | 121 ++++++++++++
 tb/tb_instr_encode_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// Request/response bundle between a program source and instr_encode_loader.
// The master side issues field-level requests; the slave side drives the memory write port.
interface instr_encode_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [5:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_kind, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, in_valid, in_kind, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Program loader: encodes field-level MIPS requests into 32-bit words and writes them,
// one per accepted request, to consecutive instruction-memory addresses.
module instr_encode_loader #(
    parameter int unsigned          ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_encode_loader_if.slave bus
);
    localparam logic [2:0] KindR    = 3'd0;
    localparam logic [2:0] KindBeq  = 3'd1;
    localparam logic [2:0] KindLw   = 3'd2;
    localparam logic [2:0] KindSw   = 3'd3;
    localparam logic [2:0] KindJ    = 3'd4;
    localparam logic [2:0] KindIAlu = 3'd5;

    typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDone, StError} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_word;
    logic              r_last;
    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_addr_max;

    assign w_addr_max = (r_addr == {ADDR_W{1'b1}});

    // Combinational encoder; only the fields a kind uses reach the word.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (bus.in_kind)
            KindR:   w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
                               bus.in_funct};
            KindBeq: w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            KindLw:  w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            KindSw:  w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            KindJ:   w_word = {6'b000010, bus.in_target};
            KindIAlu: begin
                w_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm};
                case (bus.in_op)
                    6'b001000, 6'b001001, 6'b001010, 6'b001100,
                    6'b001101, 6'b001110, 6'b001111: w_legal = 1'b1;
                    default:                         w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone, StError: begin
                if (bus.start) w_state_next = StAccept;
            end
            StAccept: begin
                if (bus.in_valid) w_state_next = w_legal ? StWrite : StError;
            end
            StWrite: begin
                if (r_last)          w_state_next = StDone;
                else if (w_addr_max) w_state_next = StError;
                else                 w_state_next = StAccept;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready   = (r_state == StAccept);
        bus.imem_we    = (r_state == StWrite);
        bus.imem_addr  = (r_state == StWrite) ? r_addr : '0;
        bus.imem_wdata = (r_state == StWrite) ? r_word : '0;
        bus.busy       = (r_state == StAccept) || (r_state == StWrite);
        bus.done       = (r_state == StDone);
        bus.err        = (r_state == StError);
        bus.count      = r_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_count <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone, StError: begin
                    if (bus.start) begin
                        r_addr  <= BASE_ADDR;
                        r_count <= '0;
                    end
                end
                StAccept: begin
                    if (bus.in_valid) begin
                        r_word <= w_word;
                        r_last <= bus.in_last;
                    end
                end
                StWrite: begin
                    r_count <= r_count + (ADDR_W + 1)'(1);
                    // The address saturates at all-ones; the overflow path exits to error.
                    if (!r_last && !w_addr_max) r_addr <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a table of single-word sessions plus
// hand-written multi-word, reset and address-overflow sequences.
module tb_instr_encode_loader;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_encode_loader_if #(.ADDR_W(8)) bus8 ();
    instr_encode_loader_if #(.ADDR_W(2)) bus2 ();

    instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start8();
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk("start_busy", 32'(bus8.busy), 32'd1);
        chk("start_ready", 32'(bus8.in_ready), 32'd1);
    endtask

    // Presents one request in ACCEPT; returns at the negedge after the handshake.
    task automatic req8(input vec_t v, input logic last);
        bus8.in_kind   = v.kind;
        bus8.in_op     = v.op;
        bus8.in_rs     = v.rs;
        bus8.in_rt     = v.rt;
        bus8.in_rd     = v.rd;
        bus8.in_shamt  = v.shamt;
        bus8.in_funct  = v.funct;
        bus8.in_imm    = v.imm;
        bus8.in_target = v.target;
        bus8.in_last   = last;
        bus8.in_valid  = 1'b1;
        chk("req_ready", 32'(bus8.in_ready), 32'd1);
        tick();
        bus8.in_valid = 1'b0;
    endtask

    task automatic chk_all_zero8(input string tag);
        chk({tag, "_we"}, 32'(bus8.imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus8.imem_addr), 32'd0);
        chk({tag, "_wdata"}, bus8.imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(bus8.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus8.done), 32'd0);
        chk({tag, "_err"}, 32'(bus8.err), 32'd0);
        chk({tag, "_count"}, 32'(bus8.count), 32'd0);
        chk({tag, "_ready"}, 32'(bus8.in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // kind op rs rt rd shamt funct imm target legal word
        vecs[0]  = '{3'd0, 6'o00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 32'h00221820};
        vecs[1]  = '{3'd0, 6'o00, 5'd0, 5'd1, 5'd2, 5'd4, 6'h00, 16'h0, 26'h0, 1'b1, 32'h00011100};
        vecs[2]  = '{3'd2, 6'o00, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1, 32'h8FA80004};
        vecs[3]  = '{3'd3, 6'o00, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b1, 32'hAFA90008};
        vecs[4]  = '{3'd1, 6'o00, 5'd1, 5'd2, 5'd7, 5'd3, 6'h3F, 16'hFFFF, 26'h0, 1'b1, 32'h1022FFFF};
        vecs[5]  = '{3'd4, 6'o77, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010, 1'b1,
                     32'h08000010};
        vecs[6]  = '{3'd6, 6'o00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 32'h0};
        vecs[7]  = '{3'd4, 6'o00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
        vecs[8]  = '{3'd5, 6'b001111, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b1, 32'h3C051234};
        vecs[9]  = '{3'd5, 6'b000100, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h1, 26'h0, 1'b0, 32'h0};
        vecs[10] = '{3'd5, 6'b001000, 5'd3, 5'd4, 5'd9, 5'd9, 6'h1, 16'h8000, 26'h0, 1'b1, 32'h20648000};
        vecs[11] = '{3'd5, 6'b001011, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 1'b0, 32'h0};
        vecs[12] = '{3'd5, 6'b001110, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b1, 32'h384300FF};
        vecs[13] = '{3'd7, 6'b001101, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'hABCD, 26'h0, 1'b0, 32'h0};

        {bus8.start, bus8.in_valid, bus8.in_kind, bus8.in_op, bus8.in_rs, bus8.in_rt} = '0;
        {bus8.in_rd, bus8.in_shamt, bus8.in_funct, bus8.in_imm, bus8.in_target} = '0;
        bus8.in_last = 1'b0;
        {bus2.start, bus2.in_valid, bus2.in_kind, bus2.in_op, bus2.in_rs, bus2.in_rt} = '0;
        {bus2.in_rd, bus2.in_shamt, bus2.in_funct, bus2.in_imm, bus2.in_target} = '0;
        bus2.in_last = 1'b0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero8("reset");
        tick();
        chk_all_zero8("idle");

        // Single-word sessions; an illegal entry is followed by a fresh start.
        for (int i = 0; i < 14; i++) begin
            start8();
            req8(vecs[i], 1'b1);
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_we", i), 32'(bus8.imem_we), 32'd1);
                chk($sformatf("v%0d_addr", i), 32'(bus8.imem_addr), 32'd0);
                chk($sformatf("v%0d_wdata", i), bus8.imem_wdata, vecs[i].word);
                chk($sformatf("v%0d_ready_low", i), 32'(bus8.in_ready), 32'd0);
                tick();
                chk($sformatf("v%0d_we_off", i), 32'(bus8.imem_we), 32'd0);
                chk($sformatf("v%0d_done", i), 32'(bus8.done), 32'd1);
                chk($sformatf("v%0d_count", i), 32'(bus8.count), 32'd1);
                chk($sformatf("v%0d_err", i), 32'(bus8.err), 32'd0);
            end else begin
                chk($sformatf("v%0d_no_we", i), 32'(bus8.imem_we), 32'd0);
                chk($sformatf("v%0d_err", i), 32'(bus8.err), 32'd1);
                chk($sformatf("v%0d_count", i), 32'(bus8.count), 32'd0);
                tick();
                chk($sformatf("v%0d_no_we2", i), 32'(bus8.imem_we), 32'd0);
                chk($sformatf("v%0d_err_hold", i), 32'(bus8.err), 32'd1);
            end
        end

        // Two-word session: lw then sw.
        start8();
        req8(vecs[2], 1'b0);
        chk("two_w0_we", 32'(bus8.imem_we), 32'd1);
        chk("two_w0_addr", 32'(bus8.imem_addr), 32'd0);
        chk("two_w0_wdata", bus8.imem_wdata, 32'h8FA80004);
        chk("two_w0_ready", 32'(bus8.in_ready), 32'd0);
        tick();
        chk("two_mid_count", 32'(bus8.count), 32'd1);
        req8(vecs[3], 1'b1);
        chk("two_w1_we", 32'(bus8.imem_we), 32'd1);
        chk("two_w1_addr", 32'(bus8.imem_addr), 32'd1);
        chk("two_w1_wdata", bus8.imem_wdata, 32'hAFA90008);
        tick();
        chk("two_done", 32'(bus8.done), 32'd1);
        chk("two_count", 32'(bus8.count), 32'd2);

        // DONE holds and ignores in_valid.
        bus8.in_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("done_hold", 32'(bus8.done), 32'd1);
            chk("done_no_we", 32'(bus8.imem_we), 32'd0);
        end
        bus8.in_valid = 1'b0;

        // Reset in the ACCEPT handshake cycle drops the request.
        start8();
        v = vecs[0];
        bus8.in_kind = v.kind;
        bus8.in_rs = v.rs;
        bus8.in_rt = v.rt;
        bus8.in_rd = v.rd;
        bus8.in_funct = v.funct;
        bus8.in_last = 1'b1;
        bus8.in_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus8.in_valid = 1'b0;
        chk_all_zero8("rst_acc");
        repeat (3) begin
            tick();
            chk("rst_acc_no_we", 32'(bus8.imem_we), 32'd0);
        end

        // Reset during WRITE: the write shows that cycle, then IDLE.
        start8();
        req8(vecs[8], 1'b1);
        chk("rst_wr_we", 32'(bus8.imem_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero8("rst_wr");

        // Address overflow on the 2-bit instance.
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.in_kind  = 3'd0;
            bus2.in_rd    = 5'(i);
            bus2.in_funct = 6'h20;
            bus2.in_last  = 1'b0;
            bus2.in_valid = 1'b1;
            chk($sformatf("ovf%0d_ready", i), 32'(bus2.in_ready), 32'd1);
            tick();
            bus2.in_valid = 1'b0;
            chk($sformatf("ovf%0d_we", i), 32'(bus2.imem_we), 32'd1);
            chk($sformatf("ovf%0d_addr", i), 32'(bus2.imem_addr), 32'(i));
            chk($sformatf("ovf%0d_wdata", i), bus2.imem_wdata, 32'h20 + 32'(i) * 32'h800);
            tick();
            if (i < 3) chk($sformatf("ovf%0d_err_low", i), 32'(bus2.err), 32'd0);
        end
        chk("ovf_err", 32'(bus2.err), 32'd1);
        chk("ovf_count", 32'(bus2.count), 32'd4);
        chk("ovf_no_we", 32'(bus2.imem_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
